// File: rtl/universal_shift_reg_if.sv
// Bundle of the data/control signals of the universal shift register.
// The master drives operation select and data; the slave is the register itself.
interface universal_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  modport master (
    output en, mode, d, sin_r, sin_l,
    input  q, sout_r, sout_l, cnt, sat
  );

  modport slave (
    input  en, mode, d, sin_r, sin_l,
    output q, sout_r, sout_l, cnt, sat
  );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift, rotate, load and clear, with a
// saturating count of shifts since the last load/clear.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  universal_shift_reg_if.slave bus
);

  typedef enum logic [2:0] {
    OP_HOLD0 = 3'b000,
    OP_SHR   = 3'b001,
    OP_SHL   = 3'b010,
    OP_LOAD  = 3'b011,
    OP_ROR   = 3'b100,
    OP_ROL   = 3'b101,
    OP_CLR   = 3'b110,
    OP_HOLD7 = 3'b111
  } op_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  op_e              op_s;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sat_q;
  logic             sat_d;

  assign op_s = op_e'(bus.mode);

  // Next-state decode of register contents and shift counter.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (bus.en) begin
      case (op_s)
        OP_SHR: begin
          shift_d = {bus.sin_r, shift_q[WIDTH-1:1]};
          cnt_d   = sat_inc(cnt_q);
        end
        OP_SHL: begin
          shift_d = {shift_q[WIDTH-2:0], bus.sin_l};
          cnt_d   = sat_inc(cnt_q);
        end
        OP_LOAD: begin
          shift_d = bus.d;
          cnt_d   = {CNT_W{1'b0}};
        end
        OP_ROR: begin
          shift_d = {shift_q[0], shift_q[WIDTH-1:1]};
          cnt_d   = sat_inc(cnt_q);
        end
        OP_ROL: begin
          shift_d = {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};
          cnt_d   = sat_inc(cnt_q);
        end
        OP_CLR: begin
          shift_d = {WIDTH{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
        end
        OP_HOLD0, OP_HOLD7: begin
          shift_d = shift_q;
          cnt_d   = cnt_q;
        end
        default: begin
          shift_d = shift_q;
          cnt_d   = cnt_q;
        end
      endcase
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
  end

  // sat is registered from the next count so it flips in the same cycle as cnt.
  assign sat_d = (cnt_d == CNT_MAX);

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      sat_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.q      = shift_q;
  assign bus.cnt    = cnt_q;
  assign bus.sat    = sat_q;
  assign bus.sout_r = shift_q[0];
  assign bus.sout_l = shift_q[WIDTH-1];

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning register width in bits (legal range 2..64).
REQ-002 SHALL have parameter CNT_W, default 4, meaning width of the shift counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state changing on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: clock enable; when 0, all state holds.
REQ-006 SHALL have port mode, input, 3 bits: operation select (see REQ-012).
REQ-007 SHALL have port d, input, WIDTH bits: parallel load data.
REQ-008 SHALL have port sin_r, input, 1 bit: serial in for shift-right, entering at the MSB.
REQ-009 SHALL have port sin_l, input, 1 bit: serial in for shift-left, entering at the LSB.
REQ-010 SHALL have output ports q (WIDTH bits, register contents), sout_r (1 bit, equal to q[0]), sout_l (1 bit, equal to q[WIDTH-1]), cnt (CNT_W bits, shifts since last load/clear) and sat (1 bit, asserted when cnt equals all-ones).

Function
REQ-011 SHALL be fully edge-triggered, with no latches and no combinational path from inputs to q, cnt or sat.
REQ-012 SHALL decode mode as follows when en=1:
- 000: hold
- 001: shift right, q <= {sin_r, q[WIDTH-1:1]}
- 010: shift left, q <= {q[WIDTH-2:0], sin_l}
- 011: parallel load, q <= d
- 100: rotate right
- 101: rotate left
- 110: synchronous clear, q <= 0
- 111: hold
REQ-013 SHALL update q one clock after the sampling edge, so there is one cycle of latency from inputs to q.
REQ-014 SHALL drive sout_r and sout_l combinationally from the current q, not from next-state.
REQ-015 SHALL set cnt to 0 on modes 011 and 110 when en=1.
REQ-016 SHALL increment cnt by 1 on modes 001, 010, 100 and 101 when en=1, saturating at 2^CNT_W-1 with no wrap-around.
REQ-017 SHALL leave cnt unchanged on modes 000 and 111, and whenever en=0.
REQ-018 SHALL make sat a registered-state decode (cnt == all-ones), updating in the same cycle as cnt.
REQ-019 SHALL treat a rotate as lossless: after WIDTH consecutive rotates in the same direction, q SHALL equal its value before the first rotate.
REQ-020 SHALL let en=0 override every mode, including clear and load.
REQ-021 SHALL treat X/Z on mode as don't-care for synthesis; the bench SHALL drive only defined values.

Reset
REQ-022 SHALL, on rst_n low, immediately and without waiting for clk, force q=0, cnt=0 and sat=0, which gives sout_r=0 and sout_l=0.
REQ-023 SHALL hold all outputs at their reset values for as long as rst_n is low, regardless of clk, en or mode.
REQ-024 SHALL apply, on the first rising clk edge after rst_n deasserts, the operation selected by en/mode at that edge.
REQ-025 SHALL abandon a shift sequence interrupted by reset mid-operation, so that q=0 and cnt=0 and no partial state survives.

Verification
REQ-026 SHALL cover parallel load then shift right: WIDTH=8, load d=8'hA5, then one shift right with sin_r=1 -> q=8'hD2, cnt=1, sout_r=0.
REQ-027 SHALL cover rotate left round trip: load 8'h81, then 8 rotate-lefts -> q goes 8'h03 after the first rotate, returns to 8'h81 after the eighth, and cnt=8.
REQ-028 SHALL cover counter saturation: CNT_W=4, 20 consecutive shift-lefts with sin_l=0 -> cnt stops at 15, sat=1 from the 15th shift onward, q=0.
REQ-029 SHALL cover enable override: en=0 with mode=110 while q=8'h3C -> q stays 8'h3C and cnt is unchanged; en=1 with mode=110 -> q=0 and cnt=0.
REQ-030 SHALL cover asynchronous reset mid-shift: after load 8'hFF and 3 shifts, assert rst_n=0 between clk edges -> q=0, cnt=0 and sat=0 before the next clk edge, held through 2 clocks of reset.
REQ-031 SHALL cover hold codes: modes 000 and 111 with en=1 -> q and cnt are unchanged over 4 clocks, with random d, sin_r and sin_l.
